psum_accum_buffer: RTL and testbench

//  Partial-sum accumulation buffer. Sits directly downstream of the row/psum controller.

---
 rtl/psum_accum_buffer_if.sv | 39 +++
 rtl/psum_accum_buffer.sv | 200 ++++++++++++++++++++
 tb/tb_psum_accum_buffer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/psum_accum_buffer_if.sv
// ---------------------------------------------------------------------------
// psum_accum_buffer_if
// Bundles the partial-sum input bus and the result-queue output bus of
// psum_accum_buffer.
//   master : the producer/consumer side (row/psum controller plus write-back)
//   slave  : the accumulation buffer itself
// Signals:
//   psumEn, first, last, headAddress, psum_in : partial-sum request
//   out_valid, out_ready, out_data, out_addr  : result queue handshake
//   ovf_err, busy                             : status
// ---------------------------------------------------------------------------
interface psum_accum_buffer_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 24,
  parameter int LANES  = 4,
  parameter int AW     = 6
);
  logic                     psumEn;
  logic                     first;
  logic                     last;
  logic [AW-1:0]            headAddress;
  logic [LANES*DATA_W-1:0]  psum_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*ACC_W-1:0]   out_data;
  logic [AW-1:0]            out_addr;
  logic                     ovf_err;
  logic                     busy;

  modport master (
    output psumEn, first, last, headAddress, psum_in, out_ready,
    input  out_valid, out_data, out_addr, ovf_err, busy
  );

  modport slave (
    input  psumEn, first, last, headAddress, psum_in, out_ready,
    output out_valid, out_data, out_addr, ovf_err, busy
  );
endinterface

// File: rtl/psum_accum_buffer.sv
// ---------------------------------------------------------------------------
// psum_accum_buffer
// Partial-sum accumulation buffer. Each psumEn cycle adds LANES signed partial
// sums into consecutive entries of a DEPTH-entry saturating accumulator array
// (lane i -> entry (headAddress+i) mod DEPTH). An op marked 'last' pushes its
// resulting sums and base address into an OQ_DEPTH-entry output queue.
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   bus.slave  : psumEn/first/last/headAddress/psum_in request,
//                out_valid/out_ready/out_data/out_addr result queue,
//                ovf_err (sticky dropped push), busy (op in flight or queue
//                non-empty)
// Configuration macro:
//   PSUM_RELU_EN : when defined, negative lanes of pushed queue entries are
//                  clamped to zero; the accumulator array keeps signed values.
// ---------------------------------------------------------------------------
module psum_accum_buffer #(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 24,
  parameter int LANES    = 4,
  parameter int DEPTH    = 64,
  parameter int OQ_DEPTH = 8
) (
  input logic               clk,
  input logic               rst,
  psum_accum_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int QW = $clog2(OQ_DEPTH);
  localparam int CW = $clog2(OQ_DEPTH + 1);
  localparam int VW = LANES * ACC_W;

  // Saturate an ACC_W+1 bit sum back into ACC_W bits.
  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W:0] v);
    logic [ACC_W-1:0] r;
    if (v[ACC_W] == v[ACC_W-1]) begin
      r = v[ACC_W-1:0];
    end else if (v[ACC_W] == 1'b0) begin
      r = {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      r = {1'b1, {(ACC_W-1){1'b0}}};
    end
    return r;
  endfunction

  // Value placed in the output queue for one lane.
  function automatic logic [ACC_W-1:0] out_lane(input logic [ACC_W-1:0] v);
    logic [ACC_W-1:0] r;
`ifdef PSUM_RELU_EN
    if (v[ACC_W-1]) begin
      r = {ACC_W{1'b0}};
    end else begin
      r = v;
    end
`else
    r = v;
`endif
    return r;
  endfunction

  // Stage 1 registers
  logic                    s1_valid_r;
  logic                    s1_first_r;
  logic                    s1_last_r;
  logic [AW-1:0]           s1_addr_r;
  logic [LANES*DATA_W-1:0] s1_psum_r;

  // Accumulator array (intentionally not reset)
  logic [ACC_W-1:0]        acc_mem_r [DEPTH];

  // Output queue: entry 0 is always the head, so outputs come straight from flops
  logic [VW-1:0]           q_data_r [OQ_DEPTH];
  logic [AW-1:0]           q_addr_r [OQ_DEPTH];
  logic [CW-1:0]           q_count_r;
  logic                    out_valid_r;
  logic                    ovf_err_r;
  logic                    busy_r;

  // Stage 2 combinational datapath
  logic [AW-1:0]           lane_addr_s [LANES];
  logic [ACC_W-1:0]        psum_ext_s  [LANES];
  logic [ACC_W:0]          sum_wide_s  [LANES];
  logic [ACC_W-1:0]        sum_s       [LANES];
  logic [VW-1:0]           push_data_s;

  // Queue control
  logic                    push_s;
  logic                    pop_s;
  logic                    full_s;
  logic                    accept_s;
  logic [CW-1:0]           wr_pos_s;
  logic [QW-1:0]           wr_idx_s;
  logic [CW-1:0]           count_nxt_s;

  // Stage 1: capture the request only when psumEn is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_first_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_addr_r  <= {AW{1'b0}};
      s1_psum_r  <= {(LANES*DATA_W){1'b0}};
    end else begin
      s1_valid_r <= bus.psumEn;
      if (bus.psumEn) begin
        s1_first_r <= bus.first;
        s1_last_r  <= bus.last;
        s1_addr_r  <= bus.headAddress;
        s1_psum_r  <= bus.psum_in;
      end
    end
  end

  // Stage 2: per-lane read, sign-extend, add and saturate
  always_comb begin
    push_data_s = {VW{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      lane_addr_s[i] = s1_addr_r + AW'(i);
      psum_ext_s[i]  = {{(ACC_W-DATA_W){s1_psum_r[i*DATA_W+DATA_W-1]}},
                        s1_psum_r[i*DATA_W +: DATA_W]};
      if (s1_first_r) begin
        sum_wide_s[i] = {psum_ext_s[i][ACC_W-1], psum_ext_s[i]};
      end else begin
        sum_wide_s[i] = {acc_mem_r[lane_addr_s[i]][ACC_W-1], acc_mem_r[lane_addr_s[i]]}
                      + {psum_ext_s[i][ACC_W-1], psum_ext_s[i]};
      end
      sum_s[i] = sat_acc(sum_wide_s[i]);
      push_data_s[i*ACC_W +: ACC_W] = out_lane(sum_s[i]);
    end
  end

  // Accumulator write-back at the end of stage 2; the next op reads it directly
  always_ff @(posedge clk) begin
    if (s1_valid_r) begin
      for (int i = 0; i < LANES; i++) begin
        acc_mem_r[lane_addr_s[i]] <= sum_s[i];
      end
    end
  end

  // Queue push/pop decision; a push to a full queue only fits if the head leaves
  always_comb begin
    push_s   = s1_valid_r & s1_last_r;
    pop_s    = (q_count_r != {CW{1'b0}}) & bus.out_ready;
    full_s   = (q_count_r == CW'(OQ_DEPTH));
    accept_s = push_s & (~full_s | pop_s);
    if (pop_s) begin
      wr_pos_s = q_count_r - CW'(1);
    end else begin
      wr_pos_s = q_count_r;
    end
    wr_idx_s = wr_pos_s[QW-1:0];
    case ({accept_s, pop_s})
      2'b10:   count_nxt_s = q_count_r + CW'(1);
      2'b01:   count_nxt_s = q_count_r - CW'(1);
      default: count_nxt_s = q_count_r;
    endcase
  end

  // Output queue storage, occupancy and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < OQ_DEPTH; k++) begin
        q_data_r[k] <= {VW{1'b0}};
        q_addr_r[k] <= {AW{1'b0}};
      end
      q_count_r   <= {CW{1'b0}};
      out_valid_r <= 1'b0;
      ovf_err_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      if (pop_s) begin
        for (int k = 0; k < OQ_DEPTH - 1; k++) begin
          q_data_r[k] <= q_data_r[k+1];
          q_addr_r[k] <= q_addr_r[k+1];
        end
        q_data_r[OQ_DEPTH-1] <= {VW{1'b0}};
        q_addr_r[OQ_DEPTH-1] <= {AW{1'b0}};
      end
      // Later assignment wins over the shift for the slot being filled
      if (accept_s) begin
        q_data_r[wr_idx_s] <= push_data_s;
        q_addr_r[wr_idx_s] <= s1_addr_r;
      end
      if (push_s & ~accept_s) begin
        ovf_err_r <= 1'b1;
      end
      q_count_r   <= count_nxt_s;
      out_valid_r <= (count_nxt_s != {CW{1'b0}});
      busy_r      <= bus.psumEn | (count_nxt_s != {CW{1'b0}});
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = q_data_r[0];
  assign bus.out_addr  = q_addr_r[0];
  assign bus.ovf_err   = ovf_err_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_psum_accum_buffer.sv
// ---------------------------------------------------------------------------
// tb_psum_accum_buffer
// Directed-vector bench for psum_accum_buffer. Expected queue entries are
// pushed into a scoreboard when an op is issued; an independent monitor pops
// and compares on every out_valid && out_ready transfer.
// Honours PSUM_RELU_EN for expected lane values.
// ---------------------------------------------------------------------------
module tb_psum_accum_buffer;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 24;
  localparam int LANES  = 4;

  typedef struct packed {
    logic [5:0]              addr;
    logic [LANES*ACC_W-1:0]  data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;
  int   pops   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  psum_accum_buffer_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LANES(LANES), .AW(6)) bus ();

  psum_accum_buffer #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .LANES(LANES), .DEPTH(64), .OQ_DEPTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  function automatic logic [ACC_W-1:0] exp_lane(input int v);
    logic [ACC_W-1:0] r;
    r = ACC_W'(v);
`ifdef PSUM_RELU_EN
    if (v < 0) r = '0;
`endif
    return r;
  endfunction

  task automatic exp_push(input int addr, input int l3, input int l2, input int l1, input int l0);
    exp_t e;
    e.addr = 6'(addr);
    e.data = {exp_lane(l3), exp_lane(l2), exp_lane(l1), exp_lane(l0)};
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one op for one cycle (caller is at #1 after a rising edge).
  task automatic drive_op(input logic f, input logic l, input int head,
                          input int l3, input int l2, input int l1, input int l0);
    bus.psumEn      = 1'b1;
    bus.first       = f;
    bus.last        = l;
    bus.headAddress = 6'(head);
    bus.psum_in     = {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
    cyc();
    bus.psumEn      = 1'b0;
    bus.first       = 1'b0;
    bus.last        = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !bus.out_valid) break;
      cyc();
    end
    check(name, {96'd0, exp_q.size(), bus.out_valid}, 128'd0);
  endtask

  // Scoreboard monitor: a transfer sampled here completes at the next rising edge
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        check("unexpected_output", 128'(bus.out_data), 128'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_data", 128'(bus.out_data), 128'(e.data));
        check("out_addr", 128'(bus.out_addr), 128'(e.addr));
      end
    end
  end

  initial begin
    int p0;
    rst             = 1'b1;
    bus.psumEn      = 1'b0;
    bus.first       = 1'b0;
    bus.last        = 1'b0;
    bus.headAddress = 6'd0;
    bus.psum_in     = 64'd0;
    bus.out_ready   = 1'b0;
    cyc();
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_out_data",  128'(bus.out_data),  128'd0);
    check("rst_out_addr",  128'(bus.out_addr),  128'd0);
    check("rst_ovf_err",   128'(bus.ovf_err),   128'd0);
    check("rst_busy",      128'(bus.busy),      128'd0);
    rst = 1'b0;
    cyc();

    // 1: overwrite then accumulate with last; 2-cycle latency
    bus.out_ready = 1'b1;
    exp_push(0, 5, 4, 3, 2);
    drive_op(1'b1, 1'b0, 0, 4, 3, 2, 1);
    drive_op(1'b0, 1'b1, 0, 1, 1, 1, 1);
    check("lat_not_yet", 128'(bus.out_valid), 128'd0);
    check("busy_inflight", 128'(bus.busy), 128'd1);
    cyc();
    check("lat_valid", 128'(bus.out_valid), 128'd1);
    wait_drain("drain_t1", 20);

    // 2: address wrap, then accumulate over the wrapped entries back-to-back
    exp_push(62, 7, 6, 5, 4);
    exp_push(0, 5, 4, 7, 6);
    drive_op(1'b1, 1'b1, 62, 7, 6, 5, 4);
    drive_op(1'b0, 1'b1, 0, 0, 0, 0, 0);
    wait_drain("drain_t2", 20);

    // 3: saturation at both ends
    drive_op(1'b1, 1'b0, 8, -1, 1, -32765, 32765);
    for (int i = 0; i < 255; i++) drive_op(1'b0, 1'b0, 8, -1, 1, -32765, 32765);
    drive_op(1'b0, 1'b0, 8, -1, 1, -160, 160);
    exp_push(8, -258, 258, -8388608, 8388607);
    drive_op(1'b0, 1'b1, 8, -1, 1, -1000, 1000);
    wait_drain("drain_t3", 20);

    // 4: nine pushes with the consumer stalled -> eight kept, ovf_err sticky
    bus.out_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k < 8) exp_push(k * 4, k * 10 + 3, k * 10 + 2, k * 10 + 1, k * 10);
      drive_op(1'b1, 1'b1, k * 4, k * 10 + 3, k * 10 + 2, k * 10 + 1, k * 10);
    end
    cyc();
    cyc();
    check("ovf_set", 128'(bus.ovf_err), 128'd1);
    check("full_valid", 128'(bus.out_valid), 128'd1);
    p0 = pops;
    bus.out_ready = 1'b1;
    wait_drain("drain_t4", 30);
    check("t4_pops", 128'(pops - p0), 128'd8);
    check("ovf_sticky", 128'(bus.ovf_err), 128'd1);

    // 5: push into a full queue while popping is accepted
    do_reset();
    check("ovf_cleared", 128'(bus.ovf_err), 128'd0);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      exp_push(k + 20, k, -k, 2 * k, 100 + k);
      drive_op(1'b1, 1'b1, k + 20, k, -k, 2 * k, 100 + k);
    end
    bus.out_ready = 1'b1;
    p0 = pops;
    wait_drain("drain_t5", 30);
    check("t5_pops", 128'(pops - p0), 128'd9);
    check("ovf_stays_0", 128'(bus.ovf_err), 128'd0);

    // 6: negative lane (ReLU-dependent), then reset mid-burst
    exp_push(20, 0, -1, 3, -5);
    drive_op(1'b1, 1'b1, 20, 0, -1, 3, -5);
    wait_drain("drain_t6", 20);
    bus.out_ready = 1'b0;
    drive_op(1'b1, 1'b1, 1, 1, 1, 1, 1);
    drive_op(1'b1, 1'b1, 2, 2, 2, 2, 2);
    bus.psumEn = 1'b1;
    bus.first  = 1'b1;
    bus.last   = 1'b1;
    cyc();
    check("pre_rst_busy", 128'(bus.busy), 128'd1);
    rst = 1'b1;
    exp_q.delete();
    cyc();
    check("mid_rst_valid", 128'(bus.out_valid), 128'd0);
    check("mid_rst_busy",  128'(bus.busy),      128'd0);
    check("mid_rst_data",  128'(bus.out_data),  128'd0);
    bus.psumEn = 1'b0;
    bus.first  = 1'b0;
    bus.last   = 1'b0;
    rst = 1'b0;
    cyc();
    check("post_rst_valid", 128'(bus.out_valid), 128'd0);
    check("post_rst_busy",  128'(bus.busy),      128'd0);

    // Works again after reset
    bus.out_ready = 1'b1;
    exp_push(33, 9, 8, 7, 6);
    drive_op(1'b1, 1'b1, 33, 9, 8, 7, 6);
    wait_drain("drain_final", 20);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
